// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: lock FSM encoding, read-return owner tags
// and the pipeline's default memory geometry.
package mem_arbiter_pkg;

  localparam int MEM_AW = 10;
  localparam int MEM_DW = 32;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOCK  = 2'd2
  } lock_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2,
    OWN_LD   = 2'd3
  } owner_e;

endpackage

// File: rtl/mem_arbiter_prio.sv
// Combinational grant select, same-cycle grants: DM beats IF unless IF is starved,
// loader only served in LOCK. A denied requester simply holds its request.
module mem_arb_prio
  import mem_arbiter_pkg::*;
(
  input  lock_state_e state_i,
  input  logic        en_i,
  input  logic        halted_i,
  input  logic        if_first_i,
  input  logic        if_req_i,
  input  logic        dm_req_i,
  input  logic        ld_req_i,
  output logic        if_gnt_o,
  output logic        dm_gnt_o,
  output logic        ld_gnt_o
);

  logic if_ok;

  assign if_ok = if_req_i && !halted_i;

  always_comb begin
    if_gnt_o = 1'b0;
    dm_gnt_o = 1'b0;
    ld_gnt_o = 1'b0;
    if (en_i) begin
      unique case (state_i)
        ST_RUN: begin
          if (if_ok && (if_first_i || !dm_req_i)) begin
            if_gnt_o = 1'b1;
          end else if (dm_req_i) begin
            dm_gnt_o = 1'b1;
          end
        end
        ST_LOCK: ld_gnt_o = ld_req_i;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-way single-port memory arbiter with loader lock; grants same cycle, read data
// one cycle later on the owner's port. Denied requesters hold their request.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW         = MEM_AW,
  parameter int DW         = MEM_DW,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          ld_lock,
  input  logic          if_req,
  input  logic          if_we,
  input  logic [AW-1:0] if_addr,
  input  logic [DW-1:0] if_wdata,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic          ld_gnt,
  output logic          ld_rvalid,
  output logic [DW-1:0] ld_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [1:0]    lock_state
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  lock_state_e   state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          if_starved;

  assign if_starved = (starve_q >= SW'(STARVE_MAX));

  // Reset gates the grant select so nothing reaches memory while rst_n is low.
  mem_arb_prio u_prio (
    .state_i    (state_q),
    .en_i       (rst_n),
    .halted_i   (halted),
    .if_first_i (if_starved),
    .if_req_i   (if_req),
    .dm_req_i   (dm_req),
    .ld_req_i   (ld_req),
    .if_gnt_o   (if_gnt),
    .dm_gnt_o   (dm_gnt),
    .ld_gnt_o   (ld_gnt)
  );

  assign mem_en = if_gnt | dm_gnt | ld_gnt;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (if_gnt) begin
      mem_we    = if_we;
      mem_addr  = if_addr;
      mem_wdata = if_wdata;
      owner_d   = if_we ? OWN_NONE : OWN_IF;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      owner_d   = dm_we ? OWN_NONE : OWN_DM;
    end else if (ld_gnt) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
      owner_d   = ld_we ? OWN_NONE : OWN_LD;
    end
  end

  // DRAIN issues nothing for one cycle so a read granted in RUN can come back first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (ld_lock) state_d = ST_DRAIN;
      ST_DRAIN: state_d = ld_lock ? ST_LOCK : ST_RUN;
      ST_LOCK:  if (!ld_lock) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (halted || !if_req || if_gnt) begin
      starve_d = '0;
    end else if (!if_starved) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      owner_q  <= OWN_NONE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
    end
  end

  assign if_rvalid  = (owner_q == OWN_IF);
  assign dm_rvalid  = (owner_q == OWN_DM);
  assign ld_rvalid  = (owner_q == OWN_LD);
  assign if_rdata   = if_rvalid ? mem_rdata : '0;
  assign dm_rdata   = dm_rvalid ? mem_rdata : '0;
  assign ld_rdata   = ld_rvalid ? mem_rdata : '0;
  assign lock_state = state_q;

endmodule
